// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_pkg
// Purpose  : Shared definitions for the sequential square-root block.
//            Holds the controller state encoding and the default radicand
//            width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

    // Default radicand width. It must be even and at least 4.
    localparam int c_DEFAULT_WIDTH = 16;

    // Controller states, with an explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sqrt_pkg
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_step
// Purpose  : One restoring digit-by-digit square-root iteration. This block
//            is purely combinational.
// Ports    : rem_in   - partial remainder entering the step
//            root_in  - partial root entering the step
//            pair     - next two radicand bits (MSB first)
//            rem_out  - partial remainder after the step
//            root_out - partial root after the step (new bit shifted in)
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH/2-1:0] rem_in,
    input  logic [WIDTH/2-1:0] root_in,
    input  logic [1:0]         pair,
    output logic [WIDTH/2:0]   rem_out,
    output logic [WIDTH/2-1:0] root_out
);

    localparam int c_HALF = WIDTH / 2;

    logic [c_HALF+1:0] w_ext;    // (rem << 2) | pair
    logic [c_HALF+1:0] w_sub;    // (root << 2) | 1
    logic              w_keep;   // trial is non-negative
    logic [c_HALF:0]   w_diff;

    // Before any step, the partial remainder is at most twice a partial root
    // that has fewer than WIDTH/2 significant bits. That bound means
    // rem_in fits in WIDTH/2 bits, and both operands of the trial fit in
    // WIDTH/2+2 bits.
    assign w_ext  = {rem_in, pair};
    assign w_sub  = {root_in, 2'b01};
    assign w_keep = (w_ext >= w_sub);

    // When the trial is kept, the true difference is the new remainder.
    // That remainder is at most 2*root, so it fits in WIDTH/2+1 bits. A
    // modular subtraction at this width is therefore exact.
    assign w_diff = w_ext[c_HALF:0] - w_sub[c_HALF:0];

    assign rem_out  = w_keep ? w_diff : w_ext[c_HALF:0];
    assign root_out = {root_in[c_HALF-2:0], w_keep};

endmodule : sqrt_step
`default_nettype wire

// File: rtl/seq_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : seq_sqrt
// Purpose  : Sequential integer square root. It computes one root bit per
//            clock using a restoring digit-by-digit algorithm, and it uses a
//            valid/ready handshake on both sides.
// Ports    : clk       - clock, all state on rising edge
//            rst_n     - synchronous active-low reset
//            in_valid  - radicand offered
//            in_ready  - block can accept a radicand (IDLE)
//            num       - unsigned radicand, WIDTH bits
//            out_valid - result available and held stable (DONE)
//            out_ready - consumer takes the result
//            res       - root (floor, or rounded when ROUND=1), WIDTH/2+1
//            rem       - floor remainder num - floor_root^2, WIDTH/2+1
// Revision : 1.0 - initial release
// ============================================================================
module seq_sqrt
    import sqrt_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int ROUND = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   num,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2:0]   res,
    output logic [WIDTH/2:0]   rem
);

    localparam int c_HALF  = WIDTH / 2;
    localparam int c_CNT_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_num;     // radicand, consumed two bits per step
    logic [c_HALF-1:0]  r_root;
    logic [c_HALF:0]    r_rem;
    logic [c_CNT_W-1:0] r_cnt;     // steps remaining minus one

    logic [c_HALF:0]    w_step_rem;
    logic [c_HALF-1:0]  w_step_root;

    // ------------------------------------------------------------------
    // Single iteration datapath
    // ------------------------------------------------------------------
    // The top bit of r_rem is only ever set by the final step, so it is
    // not needed on the step input.
    sqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (r_rem[c_HALF-1:0]),
        .root_in  (r_root),
        .pair     (r_num[WIDTH-1 -: 2]),
        .rem_out  (w_step_rem),
        .root_out (w_step_root)
    );

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num  <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_num  <= num;
                        r_root <= '0;
                        r_rem  <= '0;
                        r_cnt  <= c_CNT_W'(c_HALF - 1);
                    end
                end
                CALC: begin
                    r_num  <= {r_num[WIDTH-3:0], 2'b00};
                    r_root <= w_step_root;
                    r_rem  <= w_step_rem;
                    r_cnt  <= r_cnt - 1'b1;
                end
                default: begin
                    // DONE keeps the result unchanged.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result outputs
    // ------------------------------------------------------------------
    // The condition rem > root is the same as num > root*(root+1). An
    // integer radicand can never sit exactly halfway between two squares,
    // so this test alone selects the nearest root.
    generate
        if (ROUND != 0) begin : g_round
            logic w_round_up;
            assign w_round_up = (r_rem > {1'b0, r_root});
            assign res = {1'b0, r_root} + {{c_HALF{1'b0}}, w_round_up};
        end else begin : g_floor
            assign res = {1'b0, r_root};
        end
    endgenerate

    assign rem = r_rem;

endmodule : seq_sqrt
`default_nettype wire

// File: doc/seq_sqrt.md
SEQ_SQRT -- requirements
Module: seq_sqrt

Interface
REQ-001 SHALL have parameter WIDTH, default 16, radicand width; even, >= 4.
REQ-002 SHALL have parameter ROUND, default 0: 0 = floor root, 1 = round-to-nearest root.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  radicand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept radicand.
REQ-007 SHALL have port num  input  WIDTH  unsigned radicand.
REQ-008 SHALL have port out_valid  output  1  result held stable.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port res  output  WIDTH/2+1  unsigned root; MSB is 0 unless ROUND=1 rounds up to 2^(WIDTH/2).
REQ-011 SHALL have port rem  output  WIDTH/2+1  floor remainder, num - floor_root^2, in both modes.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL capture num, clear partial root and remainder, set iteration counter to WIDTH/2-1, go to CALC.
REQ-014 CALC: in_ready=0, out_valid=0; each edge SHALL perform one restoring digit-by-digit step: bring down the next two radicand bits MSB-first, trial = (rem<<2 | pair) - (root<<2 | 1), keep the trial if non-negative, shift 1 or 0 into root.
REQ-015 Trial subtraction SHALL be WIDTH/2+2 bits wide; no overflow for any num.
REQ-016 After exactly WIDTH/2 CALC edges, SHALL go to DONE; out_valid is therefore first high WIDTH/2 cycles after the accepting edge.
REQ-017 ROUND=1: SHALL output res = floor_root+1 when rem > floor_root, else floor_root; rem unchanged.
REQ-018 DONE: out_valid=1, in_ready=0; res and rem SHALL hold stable until out_valid & out_ready.
REQ-019 DONE with out_ready=1 SHALL return to IDLE on that edge; a back-to-back accept is possible on the next cycle, giving one radicand per WIDTH/2+2 cycles.
REQ-020 in_valid while not in IDLE SHALL be ignored; num changes after capture SHALL not affect the result.
REQ-021 out_ready while not in DONE SHALL be ignored.
REQ-022 num=0 SHALL complete with the same latency, giving res=0 and rem=0; there is no early termination.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, res=0, rem=0, out_valid=0, in_ready=1 on that edge.
REQ-024 Reset mid-CALC or in DONE SHALL discard the operation; no result SHALL later appear for it.
REQ-025 The FSM, counter and datapath registers SHALL all be reset; there is no reset-free datapath state.

Structure
REQ-026 Package sqrt_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the WIDTH default constant.
REQ-027 Sub-module sqrt_step SHALL be the purely combinational single iteration (remainder, root, bit pair in; next remainder, next root out); seq_sqrt holds the FSM, counter and registers.
REQ-028 The design SHALL contain no loops that unroll across iterations; one step per clock.

Verification
REQ-029 WIDTH=16, ROUND=0, num=49 -> out_valid 8 cycles after accept, res=7, rem=0.
REQ-030 WIDTH=16, num=50 -> res=7, rem=1; num=0 -> res=0, rem=0, same 8-cycle latency.
REQ-031 WIDTH=16, num=65535: ROUND=0 -> res=255, rem=510; ROUND=1 -> res=256, rem=510.
REQ-032 WIDTH=8, ROUND=1, num=12 -> res=3, rem=3; num=13 -> res=4, rem=4.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> res/rem stable, in_ready=0, a second in_valid is ignored; release -> IDLE next edge.
REQ-034 rst_n=0 on the 3rd CALC cycle -> next cycle in_ready=1, out_valid=0, res=0; a new num=81 then yields res=9.
